// File: rtl/gray_rx_pkg.sv
// Shared types, default sizes and the Gray-to-binary helper for gray_rx_decoder.
package gray_rx_pkg;

    // Default configuration of the decoder.
    localparam int DEF_WIDTH       = 3;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LAP_W       = 8;
    localparam int DEF_ERR_W       = 8;

    // Widest Gray code the helper function can convert.
    localparam int GRAY_MAX_W = 32;

    // FSM encoding: acquire the first value, then track transitions.
    typedef logic [0:0] state_t;
    localparam state_t ACQ   = 1'b0;
    localparam state_t TRACK = 1'b1;

    // Gray to binary for a code of width w (w <= GRAY_MAX_W).
    // Each binary bit is the XOR of its Gray bit and all Gray bits above it.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(
        input logic [GRAY_MAX_W-1:0] g,
        input int                    w
    );
        logic [GRAY_MAX_W-1:0] gm;
        logic [GRAY_MAX_W-1:0] b;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            gm[i] = (i < w) ? g[i] : 1'b0;
        end
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_rx_decoder_sync.sv
// gray_sync: WIDTH x STAGES flop chain bringing an asynchronous bus into clk.
module gray_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] sync_d [STAGES];
    logic [WIDTH-1:0] sync_q [STAGES];

    // Each stage takes the value of the stage before it.
    always_comb begin
        sync_d[0] = d_in;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Shift the chain on every clock.
    // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is a short flop chain, not a RAM, so every entry is reset.
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: resynchronises a Gray counter bus, converts it to binary and
// tracks steps, rollovers and illegal jumps. WIDTH and SYNC_STAGES must be >= 2.
// Define GRAY_RX_DIR_EN to accept -1 transitions as legal down steps; without it
// the block is up-only and a -1 transition counts as an error.
module gray_rx_decoder
    import gray_rx_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LAP_W       = DEF_LAP_W,
    parameter int ERR_W       = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             valid,
    output logic             step,
    output logic             dir,
    output logic             wrap,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

    logic [WIDTH-1:0]  g_s;
    logic [WIDTH-1:0]  b_s;
    logic [WIDTH-1:0]  bin_up;

    state_t            state_q,   state_d;
    logic [FILL_W-1:0] fill_q,    fill_d;
    logic [WIDTH-1:0]  bin_q,     bin_d;
    logic              valid_q,   valid_d;
    logic              step_q,    step_d;
    logic              dir_q,     dir_d;
    logic              wrap_q,    wrap_d;
    logic [LAP_W-1:0]  lap_q,     lap_d;
    logic              err_q,     err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    gray_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (gray_in),
        .q_out (g_s)
    );

    assign b_s    = WIDTH'(gray2bin(GRAY_MAX_W'(g_s), WIDTH));
    assign bin_up = bin_q + WIDTH'(1);

`ifdef GRAY_RX_DIR_EN
    logic [WIDTH-1:0] bin_dn;
    assign bin_dn = bin_q - WIDTH'(1);
`endif

    // Acquisition / tracking FSM with step, wrap and error classification.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        fill_d    = fill_q;
        bin_d     = bin_q;
        valid_d   = valid_q;
        step_d    = 1'b0;
        dir_d     = dir_q;
        wrap_d    = 1'b0;
        lap_d     = lap_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ACQ: begin
                // Wait until the synchroniser holds a sampled value, then adopt it silently.
                if (fill_q == FILL_DONE) begin
                    bin_d   = b_s;
                    valid_d = 1'b1;
                    state_d = TRACK;
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            TRACK: begin
                if (b_s == bin_up) begin
                    bin_d  = b_s;
                    step_d = 1'b1;
                    dir_d  = 1'b1;
                    if (bin_q == '1) begin
                        wrap_d = 1'b1;
                        lap_d  = lap_q + LAP_W'(1);
                    end
`ifdef GRAY_RX_DIR_EN
                end else if (b_s == bin_dn) begin
                    bin_d  = b_s;
                    step_d = 1'b1;
                    dir_d  = 1'b0;
                    if (bin_q == '0) begin
                        wrap_d = 1'b1;
                        lap_d  = lap_q - LAP_W'(1);
                    end
`endif
                end else if (b_s != bin_q) begin
                    // Illegal jump: flag it and resync onto the new value.
                    err_d = 1'b1;
                    bin_d = b_s;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
            end
            default: state_d = ACQ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACQ;
            fill_q    <= '0;
            bin_q     <= '0;
            valid_q   <= 1'b0;
            step_q    <= 1'b0;
            dir_q     <= 1'b1;
            wrap_q    <= 1'b0;
            lap_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            bin_q     <= bin_d;
            valid_q   <= valid_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
            lap_q     <= lap_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bin_out = bin_q;
    assign valid   = valid_q;
    assign step    = step_q;
    assign dir     = dir_q;
    assign wrap    = wrap_q;
    assign lap_cnt = lap_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Self-checking bench for gray_rx_decoder (WIDTH=3, SYNC_STAGES=2, LAP_W=8, ERR_W=8).
// Build with or without GRAY_RX_DIR_EN; the reference model follows the same macro.
module tb_gray_rx_decoder;

    localparam int LAT = 3;  // drive negedge to observed pulse, in negedges

    logic       clk;
    logic       rst_n;
    logic [2:0] gray_in;
    logic [2:0] bin_out;
    logic       valid;
    logic       step;
    logic       dir;
    logic       wrap;
    logic [7:0] lap_cnt;
    logic       err;
    logic [7:0] err_cnt;

    gray_rx_decoder #(
        .WIDTH       (3),
        .SYNC_STAGES (2),
        .LAP_W       (8),
        .ERR_W       (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .gray_in (gray_in),
        .bin_out (bin_out),
        .valid   (valid),
        .step    (step),
        .dir     (dir),
        .wrap    (wrap),
        .lap_cnt (lap_cnt),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] bin;
        logic       step;
        logic       dir;
        logic       wrap;
        logic [7:0] lap;
        logic       err;
        logic [7:0] errcnt;
        int         t;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         now_t  = 0;

    logic [2:0] m_bin;
    logic       m_dir;
    logic [7:0] m_lap;
    logic [7:0] m_errcnt;

    function automatic logic [2:0] g2b(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [2:0] b2g(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference model: classify a newly driven code and queue the expected pulse.
    task automatic push_code(input logic [2:0] g);
        exp_t       e;
        logic [2:0] b;
        logic [2:0] up;
        logic [2:0] dn;
        b  = g2b(g);
        up = m_bin + 3'd1;
        dn = m_bin - 3'd1;
        if (b == m_bin) return;
        e.step = 1'b0;
        e.wrap = 1'b0;
        e.err  = 1'b0;
        e.t    = now_t;
        if (b == up) begin
            e.step = 1'b1;
            m_dir  = 1'b1;
            if (m_bin == 3'd7) begin
                e.wrap = 1'b1;
                m_lap  = m_lap + 8'd1;
            end
`ifdef GRAY_RX_DIR_EN
        end else if (b == dn) begin
            e.step = 1'b1;
            m_dir  = 1'b0;
            if (m_bin == 3'd0) begin
                e.wrap = 1'b1;
                m_lap  = m_lap - 8'd1;
            end
`endif
        end else begin
            e.err = 1'b1;
            if (m_errcnt != 8'hFF) m_errcnt = m_errcnt + 8'd1;
        end
        m_bin    = b;
        e.bin    = m_bin;
        e.dir    = m_dir;
        e.lap    = m_lap;
        e.errcnt = m_errcnt;
        sb.push_back(e);
    endtask

    // Called once per negedge while tracking: compare DUT outputs against the scoreboard.
    task automatic sample();
        exp_t e;
        checks++;
        if (step && err) begin
            errors++;
            $display("FAIL step_err_overlap t=%0d step=%b err=%b required not both high", now_t, step, err);
        end
        if (step || err) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse t=%0d step=%b err=%b wrap=%b required none", now_t, step, err, wrap);
            end else begin
                e = sb.pop_front();
                checks++;
                if (now_t - e.t != LAT) begin
                    errors++;
                    $display("FAIL latency got=%0d required=%0d", now_t - e.t, LAT);
                end
                checks++;
                if ({step, err, wrap, dir} !== {e.step, e.err, e.wrap, e.dir}) begin
                    errors++;
                    $display("FAIL pulse_flags t=%0d step/err/wrap/dir=%b%b%b%b required=%b%b%b%b",
                             now_t, step, err, wrap, dir, e.step, e.err, e.wrap, e.dir);
                end
                checks++;
                if (bin_out !== e.bin || lap_cnt !== e.lap || err_cnt !== e.errcnt) begin
                    errors++;
                    $display("FAIL pulse_values t=%0d bin=%0d lap=%0d errcnt=%0d required bin=%0d lap=%0d errcnt=%0d",
                             now_t, bin_out, lap_cnt, err_cnt, e.bin, e.lap, e.errcnt);
                end
            end
        end else begin
            checks++;
            if (wrap !== 1'b0 || valid !== 1'b1) begin
                errors++;
                $display("FAIL idle_flags t=%0d wrap=%b valid=%b required wrap=0 valid=1", now_t, wrap, valid);
            end
            if (sb.size() == 0) begin
                checks++;
                if (bin_out !== m_bin || lap_cnt !== m_lap || err_cnt !== m_errcnt || dir !== m_dir) begin
                    errors++;
                    $display("FAIL idle_state t=%0d bin=%0d lap=%0d errcnt=%0d dir=%b required bin=%0d lap=%0d errcnt=%0d dir=%b",
                             now_t, bin_out, lap_cnt, err_cnt, dir, m_bin, m_lap, m_errcnt, m_dir);
                end
            end
        end
        if (sb.size() > 0 && now_t - sb[0].t > LAT) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse t=%0d pushed=%0d bin=%0d required step=%b err=%b", now_t, e.t, e.bin, e.step, e.err);
        end
    endtask

    // Drive one code every gap cycles, scoreboard every cycle, then drain.
    task automatic run_codes(input logic [2:0] codes[$], input int gap);
        int idx;
        int n;
        idx = 0;
        n   = codes.size() * gap + LAT + 2;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            now_t++;
            sample();
            if (idx < codes.size() && (k % gap) == 0) begin
                gray_in = codes[idx];
                push_code(codes[idx]);
                idx++;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    // Reset with a given input code and wait (bounded) for acquisition.
    task automatic apply_reset(input logic [2:0] g);
        int n;
        @(negedge clk);
        rst_n   = 1'b0;
        gray_in = g;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL acquire_timeout valid=%b required=1", valid);
        end
        m_bin    = g2b(g);
        m_dir    = 1'b1;
        m_lap    = 8'd0;
        m_errcnt = 8'd0;
        sb.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        gray_in = 3'b011;
        repeat (2) @(negedge clk);
        checks++;
        if ({bin_out, valid, step, dir, wrap, lap_cnt, err, err_cnt} !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL reset_values bin=%0d valid=%b step=%b dir=%b wrap=%b lap=%0d err=%b errcnt=%0d required 0,0,0,1,0,0,0,0",
                     bin_out, valid, step, dir, wrap, lap_cnt, err, err_cnt);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (valid !== (k == 3)) begin
                errors++;
                $display("FAIL acquire_valid edge=%0d valid=%b required=%b", k, valid, (k == 3));
            end
        end
        checks++;
        if (bin_out !== 3'd2 || step !== 1'b0 || wrap !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL acquire_value bin=%0d step=%b wrap=%b err=%b required bin=2 no pulses", bin_out, step, wrap, err);
        end
    endtask

    task automatic test_up_sequence();
        logic [2:0] cq[$];
        apply_reset(3'b000);
        for (int b = 1; b <= 8; b++) cq.push_back(b2g(3'(b)));
        run_codes(cq, 4);
        checks++;
        if (lap_cnt !== 8'd1 || bin_out !== 3'd0) begin
            errors++;
            $display("FAIL up_sequence_end lap=%0d bin=%0d required lap=1 bin=0", lap_cnt, bin_out);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] cq[$];
        cq.push_back(3'b001);
        cq.push_back(3'b110);
        run_codes(cq, 4);
        checks++;
        if (err_cnt !== 8'd1 || bin_out !== 3'd4 || step !== 1'b0) begin
            errors++;
            $display("FAIL illegal_end errcnt=%0d bin=%0d step=%b required errcnt=1 bin=4 step=0", err_cnt, bin_out, step);
        end
    endtask

    task automatic test_down();
        logic [2:0] cq[$];
        apply_reset(3'b000);
        cq.push_back(3'b100);
        run_codes(cq, 4);
`ifdef GRAY_RX_DIR_EN
        checks++;
        if (lap_cnt !== 8'd255 || dir !== 1'b0 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL down_bidir lap=%0d dir=%b errcnt=%0d required lap=255 dir=0 errcnt=0", lap_cnt, dir, err_cnt);
        end
`else
        checks++;
        if (lap_cnt !== 8'd0 || dir !== 1'b1 || err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL down_uponly lap=%0d dir=%b errcnt=%0d required lap=0 dir=1 errcnt=1", lap_cnt, dir, err_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [2:0] cq[$];
        apply_reset(3'b000);
        cq.push_back(3'b001);
        cq.push_back(3'b011);
        cq.push_back(3'b010);
        cq.push_back(3'b110);
        run_codes(cq, 1);
        checks++;
        if (bin_out !== 3'd4) begin
            errors++;
            $display("FAIL back_to_back_end bin=%0d required=4", bin_out);
        end
    endtask

    task automatic test_lap_rollover();
        logic [2:0] cq[$];
        apply_reset(3'b000);
        for (int l = 0; l < 256; l++) begin
            for (int b = 1; b <= 8; b++) cq.push_back(b2g(3'(b)));
        end
        run_codes(cq, 2);
        checks++;
        if (lap_cnt !== 8'd0) begin
            errors++;
            $display("FAIL lap_rollover lap=%0d required=0", lap_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [2:0] cq[$];
        apply_reset(3'b000);
        for (int k = 0; k < 260; k++) cq.push_back((k % 2 == 0) ? 3'b110 : 3'b000);
        run_codes(cq, 4);
        checks++;
        if (err_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL err_saturation errcnt=%0d required=255", err_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] cq[$];
        apply_reset(3'b000);
        cq.push_back(3'b001);
        cq.push_back(3'b110);
        cq.push_back(3'b111);
        run_codes(cq, 4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bin_out, valid, step, dir, wrap, lap_cnt, err, err_cnt} !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL mid_reset_clear bin=%0d valid=%b step=%b dir=%b wrap=%b lap=%0d err=%b errcnt=%0d required 0,0,0,1,0,0,0,0",
                     bin_out, valid, step, dir, wrap, lap_cnt, err, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (valid !== (k == 3)) begin
                errors++;
                $display("FAIL reacquire_valid edge=%0d valid=%b required=%b", k, valid, (k == 3));
            end
        end
        checks++;
        if (bin_out !== 3'd5 || err_cnt !== 8'd0 || err !== 1'b0 || step !== 1'b0) begin
            errors++;
            $display("FAIL reacquire_value bin=%0d errcnt=%0d err=%b step=%b required bin=5 errcnt=0 no pulses",
                     bin_out, err_cnt, err, step);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        gray_in = 3'b000;
        test_reset();
        test_up_sequence();
        test_illegal();
        test_down();
        test_back_to_back();
        test_lap_rollover();
        test_saturation();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
